// File: rtl/branch_predictor.sv
// Branch predictor: a direct-mapped branch target buffer in which every entry
// holds a 2-bit saturating direction counter. Fetch looks up a PC and gets a
// registered prediction one cycle later. Execute reports resolved branches,
// which train the table and raise a one-cycle redirect on a misprediction.
//
// Handshake semantics: there is no backpressure. fetch_valid and resolve_valid
// are single-cycle qualifiers, so each cycle in which one is high is exactly one
// transaction. pred_valid and mispredict are single-cycle qualifiers one cycle
// later. Payloads (pred_taken/pred_target, redirect_pc) hold their value while
// their qualifier is low.
module branch_predictor #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 32 - IDX_W - 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        resolve_valid,
    input  logic [31:0] resolve_pc,
    input  logic        resolve_taken,
    input  logic [31:0] resolve_target,
    input  logic        resolve_pred_taken,
    input  logic [31:0] resolve_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] mispredict_count
);

    localparam int ENTRIES = 1 << IDX_W;

    // Table storage, one element per entry
    logic             entry_valid_q  [ENTRIES];
    logic [TAG_W-1:0] entry_tag_q    [ENTRIES];
    logic [1:0]       entry_ctr_q    [ENTRIES];
    logic [31:0]      entry_target_q [ENTRIES];

    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic [IDX_W-1:0] resolve_idx;
    logic [TAG_W-1:0] resolve_tag;
    logic             fetch_hit;
    logic             fetch_taken;
    logic             resolve_hit;
    logic             resolve_wrong;

    assign fetch_idx   = fetch_pc[IDX_W+1:2];
    assign fetch_tag   = fetch_pc[31:IDX_W+2];
    assign resolve_idx = resolve_pc[IDX_W+1:2];
    assign resolve_tag = resolve_pc[31:IDX_W+2];

    // Hit detection and misprediction condition; reads use the pre-update table
    always_comb begin
        fetch_hit     = entry_valid_q[fetch_idx] && (entry_tag_q[fetch_idx] == fetch_tag);
        fetch_taken   = fetch_hit && entry_ctr_q[fetch_idx][1];
        resolve_hit   = entry_valid_q[resolve_idx] && (entry_tag_q[resolve_idx] == resolve_tag);
        resolve_wrong = (resolve_taken != resolve_pred_taken) ||
                        (resolve_taken && (resolve_pred_target != resolve_target));
    end

    // Registered lookup result; direction/target hold when no lookup is issued
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pred_valid  <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= 32'd0;
        end else begin
            pred_valid <= fetch_valid;
            if (fetch_valid) begin
                pred_taken  <= fetch_taken;
                pred_target <= fetch_taken ? entry_target_q[fetch_idx] : fetch_pc + 32'd4;
            end
        end
    end

    // Table training from resolved branches; not-taken misses never allocate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_valid_q[i]  <= 1'b0;
                entry_tag_q[i]    <= '0;
                entry_ctr_q[i]    <= 2'b01;
                entry_target_q[i] <= 32'd0;
            end
        end else if (resolve_valid) begin
            if (resolve_hit) begin
                if (resolve_taken) begin
                    if (entry_ctr_q[resolve_idx] != 2'b11) begin
                        entry_ctr_q[resolve_idx] <= entry_ctr_q[resolve_idx] + 2'd1;
                    end
                    entry_target_q[resolve_idx] <= resolve_target;
                end else if (entry_ctr_q[resolve_idx] != 2'b00) begin
                    entry_ctr_q[resolve_idx] <= entry_ctr_q[resolve_idx] - 2'd1;
                end
            end else if (resolve_taken) begin
                entry_valid_q[resolve_idx]  <= 1'b1;
                entry_tag_q[resolve_idx]    <= resolve_tag;
                entry_ctr_q[resolve_idx]    <= 2'b10;
                entry_target_q[resolve_idx] <= resolve_target;
            end
        end
    end

    // Redirect strobe, correct next PC and saturating misprediction counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mispredict       <= 1'b0;
            redirect_pc      <= 32'd0;
            mispredict_count <= 32'd0;
        end else begin
            mispredict <= resolve_valid && resolve_wrong;
            if (resolve_valid && resolve_wrong) begin
                redirect_pc <= resolve_taken ? resolve_target : resolve_pc + 32'd4;
                if (mispredict_count != 32'hFFFF_FFFF) begin
                    mispredict_count <= mispredict_count + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed steps followed by random traffic, each
// cycle checked against a behavioural model of the predictor table.
module tb_branch_predictor;

    localparam int W = 99;  // {pv, pt, ptgt[32], mp, redir[32], count[32]}

    logic        clk;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        resolve_pred_taken;
    logic [31:0] resolve_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] mispredict_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];

    // Behavioural model: table of entries with an integer strength 0..3
    bit          m_valid [64];
    int unsigned m_tag   [64];
    int          m_ctr   [64];
    int unsigned m_tgt   [64];
    bit          m_pv;
    bit          m_pt;
    int unsigned m_ptgt;
    bit          m_mp;
    int unsigned m_redir;
    longint unsigned m_count;

    branch_predictor dut (
        .clk                 (clk),
        .reset               (reset),
        .fetch_valid         (fetch_valid),
        .fetch_pc            (fetch_pc),
        .pred_valid          (pred_valid),
        .pred_taken          (pred_taken),
        .pred_target         (pred_target),
        .resolve_valid       (resolve_valid),
        .resolve_pc          (resolve_pc),
        .resolve_taken       (resolve_taken),
        .resolve_target      (resolve_target),
        .resolve_pred_taken  (resolve_pred_taken),
        .resolve_pred_target (resolve_pred_target),
        .mispredict          (mispredict),
        .redirect_pc         (redirect_pc),
        .mispredict_count    (mispredict_count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_ctr[i]   = 1;
            m_tgt[i]   = 0;
        end
        m_pv = 0; m_pt = 0; m_ptgt = 0; m_mp = 0; m_redir = 0; m_count = 0;
    endtask

    function automatic bit model_hit(input int unsigned pc);
        int idx;
        idx = int'((pc / 4) % 64);
        return m_valid[idx] && (m_tag[idx] == pc / 256);
    endfunction

    function automatic bit model_taken(input int unsigned pc);
        return model_hit(pc) && (m_ctr[(pc / 4) % 64] >= 2);
    endfunction

    function automatic int unsigned model_next(input int unsigned pc);
        return model_taken(pc) ? m_tgt[(pc / 4) % 64] : pc + 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".pred_valid"},  {31'd0, pred_valid}, 32'd0);
        chk({tag, ".pred_taken"},  {31'd0, pred_taken}, 32'd0);
        chk({tag, ".pred_target"}, pred_target, 32'd0);
        chk({tag, ".mispredict"},  {31'd0, mispredict}, 32'd0);
        chk({tag, ".redirect_pc"}, redirect_pc, 32'd0);
        chk({tag, ".count"},       mispredict_count, 32'd0);
    endtask

    task automatic drive_idle();
        fetch_valid = 0; fetch_pc = 0;
        resolve_valid = 0; resolve_pc = 0; resolve_taken = 0; resolve_target = 0;
        resolve_pred_taken = 0; resolve_pred_target = 0;
    endtask

    // One clock: drive at negedge, predict, check 1 time unit after posedge
    task automatic cycle(input bit fv, input int unsigned fpc,
                         input bit rv, input int unsigned rpc, input bit rt,
                         input int unsigned rtgt, input bit rpt, input int unsigned rptgt);
        logic [W-1:0] e;
        int idx;
        bit wrong;
        @(negedge clk);
        fetch_valid = fv; fetch_pc = fpc;
        resolve_valid = rv; resolve_pc = rpc; resolve_taken = rt; resolve_target = rtgt;
        resolve_pred_taken = rpt; resolve_pred_target = rptgt;
        // lookup sees the table as it was before this edge
        m_pv = fv;
        if (fv) begin
            m_pt   = model_taken(fpc);
            m_ptgt = model_next(fpc);
        end
        wrong = (rt != rpt) || (rt && (rptgt != rtgt));
        m_mp = rv && wrong;
        if (m_mp) begin
            m_redir = rt ? rtgt : rpc + 4;
            if (m_count < 64'hFFFF_FFFF) m_count++;
        end
        if (rv) begin
            idx = int'((rpc / 4) % 64);
            if (model_hit(rpc)) begin
                if (rt) begin
                    m_ctr[idx] = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
                    m_tgt[idx] = rtgt;
                end else begin
                    m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
                end
            end else if (rt) begin
                m_valid[idx] = 1; m_tag[idx] = rpc / 256; m_ctr[idx] = 2; m_tgt[idx] = rtgt;
            end
        end
        exp_q.push_back({m_pv, m_pt, m_ptgt, m_mp, m_redir, m_count[31:0]});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("pred_valid",  {31'd0, pred_valid}, {31'd0, e[98]});
        chk("pred_taken",  {31'd0, pred_taken}, {31'd0, e[97]});
        chk("pred_target", pred_target, e[96:65]);
        chk("mispredict",  {31'd0, mispredict}, {31'd0, e[64]});
        chk("redirect_pc", redirect_pc, e[63:32]);
        chk("count",       mispredict_count, e[31:0]);
    endtask

    task automatic fetch(input int unsigned pc);
        cycle(1, pc, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic resolve(input int unsigned pc, input bit t, input int unsigned tgt,
                           input bit pt, input int unsigned ptgt);
        cycle(0, 0, 1, pc, t, tgt, pt, ptgt);
    endtask

    initial begin
        int unsigned pool [5];
        int unsigned pc;
        int unsigned tgt;
        bit t;
        pool[0] = 32'h100; pool[1] = 32'h200; pool[2] = 32'h300;
        pool[3] = 32'h40;  pool[4] = 32'h1040;

        // Reset state
        drive_idle();
        model_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 0;

        // Cold lookup: not taken, fall-through
        fetch(32'h100);
        chk("cold.target", pred_target, 32'h104);

        // First taken resolve allocates and mispredicts
        resolve(32'h100, 1, 32'h80, 0, 32'h104);
        chk("alloc.redirect", redirect_pc, 32'h80);
        chk("alloc.count", mispredict_count, 32'd1);
        fetch(32'h100);
        chk("alloc.mp_one_cycle", {31'd0, mispredict}, 32'd0);
        chk("alloc.target", pred_target, 32'h80);

        // Saturate up, then two not-taken steps back to weakly not-taken
        repeat (3) resolve(32'h100, 1, 32'h80, 1, 32'h80);
        resolve(32'h100, 0, 32'h80, 1, 32'h80);
        resolve(32'h100, 0, 32'h80, 1, 32'h80);
        fetch(32'h100);
        chk("decay.taken", {31'd0, pred_taken}, 32'd0);
        chk("decay.target", pred_target, 32'h104);

        // Aliasing: same index, different tag misses
        resolve(32'h100, 1, 32'h80, 0, 32'h104);
        fetch(32'h100);
        fetch(32'h200);
        chk("alias.target", pred_target, 32'h204);

        // Same-cycle allocate and lookup returns pre-update entry
        cycle(1, 32'h300, 1, 32'h300, 1, 32'h500, 0, 32'h304);
        chk("rbw.taken", {31'd0, pred_taken}, 32'd0);
        fetch(32'h300);
        chk("rbw.refetch", pred_target, 32'h500);

        // Not-taken mispredict redirects to fall-through
        resolve(32'h40, 0, 32'h20, 1, 32'h20);
        chk("nt.redirect", redirect_pc, 32'h44);

        // Wrong target with correct direction still mispredicts
        resolve(32'h300, 1, 32'h600, 1, 32'h500);

        // Counter saturation
        force dut.mispredict_count = 32'hFFFF_FFFF;
        #1;
        release dut.mispredict_count;
        m_count = 64'hFFFF_FFFF;
        resolve(32'h40, 0, 32'h20, 1, 32'h20);
        chk("sat.count", mispredict_count, 32'hFFFF_FFFF);

        // Reset in the middle of a pending redirect
        resolve(32'h140, 1, 32'h900, 0, 32'h144);
        #2;
        reset = 1;
        #1;
        chk_all_zero("midreset");
        model_reset();
        drive_idle();
        @(negedge clk);
        reset = 0;
        fetch(32'h300);
        chk("midreset.table", {31'd0, pred_taken}, 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            pc  = ($urandom_range(0, 5) == 5) ? $urandom() : pool[$urandom_range(0, 4)];
            tgt = $urandom() & 32'hFFFF_FFFC;
            t   = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 1) == 1)
                cycle($urandom_range(0, 1) == 1, pool[$urandom_range(0, 4)],
                      $urandom_range(0, 3) != 0, pc, t, tgt, model_taken(pc), model_next(pc));
            else
                cycle($urandom_range(0, 1) == 1, pc,
                      $urandom_range(0, 3) != 0, pc, t, tgt,
                      $urandom_range(0, 1) == 1, $urandom());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
- Fetch side: supplies a predicted direction and target one cycle after a lookup request.
- Execute side: receives the resolved outcome of each conditional branch from the branch unit, updates the table and flags mispredictions.
- Sits between the fetch stage (lookup) and execute stage (resolve); owns the redirect request sent back to fetch.

Parameters:
- IDX_W, 6, index width; table holds 2**IDX_W entries.
- TAG_W, 32-IDX_W-2, tag width stored per entry (pc[31:IDX_W+2]).

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- fetch_valid  in  1  lookup request this cycle
- fetch_pc  in  32  PC of instruction being fetched
- pred_valid  out  1  registered; high one cycle after fetch_valid
- pred_taken  out  1  registered predicted direction
- pred_target  out  32  registered predicted next PC
- resolve_valid  in  1  a conditional branch resolved in execute this cycle
- resolve_pc  in  32  PC of the resolved branch
- resolve_taken  in  1  actual outcome from the branch unit
- resolve_target  in  32  computed taken target (pc + B-immediate)
- resolve_pred_taken  in  1  direction that was predicted for this branch
- resolve_pred_target  in  32  next PC that was predicted for this branch
- mispredict  out  1  registered single-cycle redirect strobe
- redirect_pc  out  32  registered correct next PC, valid while mispredict=1
- mispredict_count  out  32  saturating count of mispredictions

Behaviour:
- Reset (async): all entry valid bits 0, counters 2'b01, targets 0; pred_valid=0, pred_taken=0, pred_target=0, mispredict=0, redirect_pc=0, mispredict_count=0.
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Lookup (latency 1): fetch_valid in cycle N -> pred_* valid in cycle N+1.
  - hit = valid && tag match; pred_taken = hit && ctr[1]; pred_target = pred_taken ? stored target : fetch_pc+4 (mod 2**32).
  - fetch_valid=0 -> pred_valid=0 next cycle; pred_taken and pred_target hold.
- Read-before-write: a lookup and an update to the same index in the same cycle returns the pre-update entry.
- Update on resolve_valid, at the same clock edge:
  - Hit, taken: ctr saturating +1 (max 2'b11); target <= resolve_target.
  - Hit, not taken: ctr saturating -1 (min 2'b00); target unchanged.
  - Miss, taken: allocate/overwrite entry; valid=1, tag, target, ctr=2'b10.
  - Miss, not taken: no change (no allocation).
- Mispredict, registered one cycle after resolve_valid:
  - Condition: resolve_taken != resolve_pred_taken, or (resolve_taken && resolve_pred_target != resolve_target).
  - mispredict is high for exactly one cycle.
  - redirect_pc = resolve_taken ? resolve_target : resolve_pc+4.
  - mispredict_count increments by 1 on the same edge and saturates at 32'hFFFF_FFFF.
- Back-to-back resolves are each handled independently; the second sees the table state written by the first.
- Reset asserted mid-operation clears all state immediately; pending mispredict is dropped.

Test Plan:
- Reset, then fetch_pc=0x100 -> next cycle pred_valid=1, pred_taken=0, pred_target=0x104.
- Resolve pc=0x100 taken, target=0x80, pred_taken=0 -> mispredict=1 for one cycle, redirect_pc=0x80, count=1; next lookup of 0x100 gives pred_taken=1, pred_target=0x80.
- Resolve pc=0x100 taken three more times -> ctr saturates at 2'b11; two not-taken resolves -> ctr=2'b01, lookup gives pred_taken=0, pred_target=0x104.
- Aliasing: with IDX_W=6, pc 0x100 entry taken; lookup 0x200 (same index, different tag) -> miss, pred_taken=0, pred_target=0x204.
- Same cycle: resolve allocates 0x300 while fetching 0x300 -> prediction not-taken; refetch one cycle later -> taken.
- Resolve not-taken with pred_taken=1 for pc=0x40 -> redirect_pc=0x44; force count to 32'hFFFF_FFFF, mispredict again -> count stays 32'hFFFF_FFFF; assert reset mid-stream -> all outputs 0 immediately.
